magnetron_sequencer: RTL and testbench

MAGNETRON_SEQUENCER -- requirements
Module: magnetron_sequencer

---
 rtl/magnetron_sequencer_if.sv | 23 ++
 rtl/magnetron_sequencer.sv | 101 ++++++++++
 tb/tb_magnetron_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/magnetron_sequencer_if.sv
// Keypad/door/timebase inputs and magnetron/status outputs of the cook sequencer.
interface magnetron_sequencer_if;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       sec_tick;
  logic [9:0] time_in;
  logic [3:0] power_level;
  logic       magnetron_on;
  logic [9:0] time_left;
  logic [1:0] state;
  logic       done_beep;

  modport master (
    output startn, stopn, clearn, door_closed, sec_tick, time_in, power_level,
    input  magnetron_on, time_left, state, done_beep
  );
  modport slave (
    input  startn, stopn, clearn, door_closed, sec_tick, time_in, power_level,
    output magnetron_on, time_left, state, done_beep
  );
endinterface

// File: rtl/magnetron_sequencer.sv
// Microwave cook sequencer: countdown timer, power-level duty cycling within a
// DUTY_WINDOW-second window, pause/resume on stop or door, timed end-of-cook beep.
module magnetron_sequencer #(
  parameter int DONE_HOLD   = 3,
  parameter int DUTY_WINDOW = 10
) (
  input logic                  clk,
  input logic                  rst,
  magnetron_sequencer_if.slave bus
);
  localparam int PW = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;
  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, COOK = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

  state_t        st_q, st_d;
  logic [9:0]    tl_q, tl_d;
  logic [PW-1:0] ph_q, ph_d, ph_next;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    pwr_q, pwr_d, pwr_in;
  logic          mag_q, mag_d;
  logic          halt;

  // Out-of-range power settings run at full power.
  assign pwr_in  = (bus.power_level == 4'd0 || bus.power_level > 4'd10) ? 4'd10 : bus.power_level;
  assign ph_next = (ph_q == PW'(DUTY_WINDOW - 1)) ? '0 : ph_q + PW'(1);
  assign halt    = !bus.stopn || !bus.door_closed;

  always_comb begin
    st_d   = st_q;
    tl_d   = tl_q;
    ph_d   = ph_q;
    hold_d = hold_q;
    pwr_d  = pwr_q;
    case (st_q)
      IDLE: begin
        if (bus.clearn && !halt && !bus.startn && bus.time_in != 10'd0) begin
          st_d  = COOK;
          tl_d  = bus.time_in;
          pwr_d = pwr_in;
          ph_d  = '0;
        end
      end
      COOK: begin
        if (!bus.clearn) begin
          st_d = IDLE;
          tl_d = 10'd0;
        end else if (halt) begin
          st_d = PAUSE;
        end else if (bus.sec_tick) begin
          tl_d = tl_q - 10'd1;
          ph_d = ph_next;
          if (tl_q == 10'd1) st_d = DONE;
        end
      end
      PAUSE: begin
        if (!bus.clearn) begin
          st_d = IDLE;
          tl_d = 10'd0;
        end else if (!halt && !bus.startn) begin
          st_d = COOK;
        end
      end
      DONE: begin
        if (!bus.clearn) begin
          st_d = IDLE;
        end else if (bus.sec_tick) begin
          if (hold_q == HW'(DONE_HOLD - 1)) st_d = IDLE;
          else hold_d = hold_q + HW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    // Hold counter only lives inside DONE; every entry starts from zero.
    if (st_d != DONE) hold_d = '0;
    mag_d = (st_d == COOK) && (int'(ph_d) < int'(pwr_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      tl_q   <= 10'd0;
      ph_q   <= '0;
      hold_q <= '0;
      pwr_q  <= 4'd10;
      mag_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      tl_q   <= tl_d;
      ph_q   <= ph_d;
      hold_q <= hold_d;
      pwr_q  <= pwr_d;
      mag_q  <= mag_d;
    end
  end

  assign bus.state        = st_q;
  assign bus.time_left    = tl_q;
  assign bus.magnetron_on = mag_q;
  assign bus.done_beep    = (st_q == DONE);
endmodule

// File: tb/tb_magnetron_sequencer.sv
// Directed scenarios plus random keypad/door/tick traffic against a behavioural cook model.
module tb_magnetron_sequencer;
  localparam int DONE_HOLD   = 3;
  localparam int DUTY_WINDOW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  magnetron_sequencer_if bus();

  magnetron_sequencer #(.DONE_HOLD(DONE_HOLD), .DUTY_WINDOW(DUTY_WINDOW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: 0 idle, 1 cooking, 2 paused, 3 done.
  int m_state = 0, m_tl = 0, m_phase = 0, m_pwr = 10, m_hold = 0;
  int secs_cooked = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit clr, hlt, go, tk;
    clr = !bus.clearn;
    hlt = !bus.stopn || !bus.door_closed;
    go  = !bus.startn;
    tk  = bus.sec_tick;
    if (rst) begin
      m_state = 0; m_tl = 0; m_phase = 0; m_pwr = 10; m_hold = 0;
      return;
    end
    if (m_state == 0) begin
      if (!clr && !hlt && go && bus.time_in != 0) begin
        m_state = 1;
        m_tl    = int'(bus.time_in);
        m_pwr   = (bus.power_level >= 1 && bus.power_level <= 10) ? int'(bus.power_level) : 10;
        m_phase = 0;
      end
    end else if (m_state == 1) begin
      if (clr) begin m_state = 0; m_tl = 0; end
      else if (hlt) m_state = 2;
      else if (tk) begin
        m_tl--;
        m_phase = (m_phase + 1) % DUTY_WINDOW;
        if (m_tl == 0) begin m_state = 3; m_hold = 0; end
      end
    end else if (m_state == 2) begin
      if (clr) begin m_state = 0; m_tl = 0; end
      else if (!hlt && go) m_state = 1;
    end else begin
      if (clr) m_state = 0;
      else if (tk) begin
        m_hold++;
        if (m_hold == DONE_HOLD) m_state = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("state", int'(bus.state), m_state);
    chk("time_left", int'(bus.time_left), m_tl);
    chk("magnetron_on", int'(bus.magnetron_on), (m_state == 1 && m_phase < m_pwr) ? 1 : 0);
    chk("done_beep", int'(bus.done_beep), (m_state == 3) ? 1 : 0);
  endtask

  task automatic idle_inputs();
    bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    bus.door_closed = 1'b1; bus.sec_tick = 1'b0;
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1; step();
    bus.sec_tick = 1'b0; step();
  endtask

  task automatic start(input int t, input int p);
    bus.time_in = 10'(t); bus.power_level = 4'(p);
    bus.startn = 1'b0; step();
    bus.startn = 1'b1;
  endtask

  initial begin
    idle_inputs();
    bus.time_in = 10'd0; bus.power_level = 4'd10;
    step(); step();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_mag", int'(bus.magnetron_on), 0);
    rst = 1'b0;
    step();

    // Full-power 5 s cook, done beep, back to idle.
    start(5, 10);
    chk("cook5_state", int'(bus.state), 1);
    chk("cook5_tl", int'(bus.time_left), 5);
    chk("cook5_mag", int'(bus.magnetron_on), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("cook5_done", int'(bus.state), 3);
    chk("cook5_beep", int'(bus.done_beep), 1);
    for (int i = 0; i < DONE_HOLD; i++) tick();
    chk("cook5_idle", int'(bus.state), 0);

    // Power 3: on for phases 0-2 of each 10 s window.
    start(20, 3);
    chk("duty_p0", int'(bus.magnetron_on), 1);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("duty_pat", int'(bus.magnetron_on), ((i % 10) < 3) ? 1 : 0);
    end
    bus.clearn = 1'b0; step(); bus.clearn = 1'b1; step();

    // Door opens at 7 s left; ticks ignored; resume from 7.
    start(12, 10);
    for (int i = 0; i < 5; i++) tick();
    bus.door_closed = 1'b0; step();
    chk("door_pause", int'(bus.state), 2);
    chk("door_mag", int'(bus.magnetron_on), 0);
    tick(); tick();
    bus.startn = 1'b0; step();
    chk("door_open_start", int'(bus.state), 2);
    bus.door_closed = 1'b1; step(); bus.startn = 1'b1;
    chk("resume_state", int'(bus.state), 1);
    chk("resume_tl", int'(bus.time_left), 7);

    // Pause: clear beats start. Cook: stop beats tick.
    bus.stopn = 1'b0; step(); bus.stopn = 1'b1;
    bus.clearn = 1'b0; bus.startn = 1'b0; step(); idle_inputs();
    chk("clr_over_start", int'(bus.state), 0);
    chk("clr_tl", int'(bus.time_left), 0);
    start(9, 5);
    bus.stopn = 1'b0; bus.sec_tick = 1'b1; step(); idle_inputs();
    chk("stop_over_tick", int'(bus.state), 2);
    chk("stop_tl", int'(bus.time_left), 9);
    bus.clearn = 1'b0; step(); bus.clearn = 1'b1;

    // Power 0 and 15 clamp to 10; zero time is ignored.
    start(15, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("pwr0_mag", int'(bus.magnetron_on), 1);
    end
    bus.clearn = 1'b0; step(); bus.clearn = 1'b1;
    start(15, 15);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("pwr15_mag", int'(bus.magnetron_on), 1);
    end
    bus.clearn = 1'b0; step(); bus.clearn = 1'b1;
    start(0, 5);
    chk("zero_time", int'(bus.state), 0);
    chk("zero_mag", int'(bus.magnetron_on), 0);

    // Reset mid-cook, then restart reloads time_in.
    start(50, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_tl", int'(bus.time_left), 40);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_cook_state", int'(bus.state), 0);
    chk("rst_cook_tl", int'(bus.time_left), 0);
    chk("rst_cook_mag", int'(bus.magnetron_on), 0);
    chk("rst_cook_beep", int'(bus.done_beep), 0);
    step();
    chk("no_resume", int'(bus.state), 0);
    start(33, 10);
    chk("reload_tl", int'(bus.time_left), 33);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      bus.startn      = ($urandom_range(0, 3) != 0);
      bus.stopn       = ($urandom_range(0, 24) != 0);
      bus.clearn      = ($urandom_range(0, 59) != 0);
      bus.door_closed = ($urandom_range(0, 24) != 0);
      bus.sec_tick    = ($urandom_range(0, 2) == 0);
      bus.time_in     = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 30));
      bus.power_level = 4'($urandom_range(0, 15));
      step();
      if (m_state == 1 && bus.sec_tick) secs_cooked++;
    end
    rst = 1'b0; idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
